// File: rtl/inst_loader.sv
// Instruction loader: takes a count byte and then little-endian instruction bytes from the UART and writes whole words to instruction memory.
// Optional inter-byte watchdog is compiled in with `define LOADER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module inst_loader #(
   parameter int NB_DATA        = 32,
   parameter int N_BITS_DATA    = 8,
   parameter int N_BYTES        = 4,
   parameter int MAX_INST       = 64,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [N_BITS_DATA-1:0] rx_data_i,
   input  logic                   rx_valid_i,
   output logic                   en_write_o,
   output logic [NB_DATA-1:0]     address_o,
   output logic [NB_DATA-1:0]     inst_load_o,
   output logic [N_BITS_DATA-1:0] n_inst_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [2:0]             state_o
);

   // Handshake: a byte is accepted in any cycle where rx_valid_i is high and the FSM is in
   // WAIT_COUNT, RECV or WRITE; there is no back-pressure, so the sender never stalls.
   typedef enum logic [2:0] {IDLE, WAIT_COUNT, RECV, WRITE, DONE} state_t;

   localparam int BC_W = $clog2(N_BYTES + 1);
   localparam int WC_W = $clog2(MAX_INST + 1);
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(N_BYTES - 1);

   state_t            state, state_n;
   logic [BC_W-1:0]   byte_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [WC_W-1:0]   word_cnt_inc;
   logic              count_bad;
   logic              err_n;
   logic              err_q;
   logic              timeout;

   assign word_cnt_inc = word_cnt + 1'b1;
   assign count_bad    = (rx_data_i == '0) || (int'(rx_data_i) > MAX_INST);

`ifdef LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wdog;

   // Counts consecutive byte-less cycles while waiting for input; any accepted byte restarts it.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         wdog <= '0;
      else if ((state == WAIT_COUNT || state == RECV) && !rx_valid_i)
         wdog <= wdog + 1'b1;
      else
         wdog <= '0;
   end

   assign timeout = (wdog == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_n = WAIT_COUNT;
         end
         WAIT_COUNT: begin
            if (rx_valid_i) begin
               if (count_bad) begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end else begin
                  state_n = RECV;
               end
            end else if (timeout) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end
         end
         RECV: begin
            if (rx_valid_i) begin
               if (byte_cnt == LAST_BYTE) state_n = WRITE;
            end else if (timeout) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end
         end
         WRITE: begin
            if (int'(word_cnt_inc) == int'(n_inst_o)) state_n = DONE;
            else                                      state_n = RECV;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         byte_cnt    <= '0;
         word_cnt    <= '0;
         n_inst_o    <= '0;
         inst_load_o <= '0;
         address_o   <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= err_n;
         case (state)
            WAIT_COUNT: begin
               if (rx_valid_i) begin
                  n_inst_o <= rx_data_i;
                  byte_cnt <= '0;
                  word_cnt <= '0;
               end
            end
            RECV: begin
               if (rx_valid_i) begin
                  inst_load_o[int'(byte_cnt)*N_BITS_DATA +: N_BITS_DATA] <= rx_data_i;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt  <= '0;
                     address_o <= NB_DATA'(word_cnt) << 2;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               // A byte landing in the write cycle already belongs to the next word.
               word_cnt <= word_cnt_inc;
               if (rx_valid_i) begin
                  inst_load_o[N_BITS_DATA-1:0] <= rx_data_i;
                  byte_cnt <= BC_W'(1);
               end else begin
                  byte_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign en_write_o = (state == WRITE);
   assign done_o     = (state == DONE);
   assign busy_o     = (state != IDLE);
   assign err_o      = err_q;
   assign state_o    = state;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: event-queue reference model, randomized loads, directed corner cases.
module tb_inst_loader;

   localparam int MAXI = 64;
   localparam int TO   = 100;
   localparam int EW   = 66;
   localparam logic [1:0] K_WRITE = 2'd0;
   localparam logic [1:0] K_DONE  = 2'd1;
   localparam logic [1:0] K_ERR   = 2'd2;

   logic        clock_i    = 1'b0;
   logic        reset_i    = 1'b0;
   logic        start_i    = 1'b0;
   logic [7:0]  rx_data_i  = '0;
   logic        rx_valid_i = 1'b0;
   logic        en_write_o;
   logic [31:0] address_o;
   logic [31:0] inst_load_o;
   logic [7:0]  n_inst_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [2:0]  state_o;

   inst_loader #(
      .NB_DATA(32), .N_BITS_DATA(8), .N_BYTES(4), .MAX_INST(MAXI), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
      .en_write_o(en_write_o), .address_o(address_o), .inst_load_o(inst_load_o),
      .n_inst_o(n_inst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .state_o(state_o)
   );

   // clock / reset
   always #5 clock_i = ~clock_i;

   int cyc = 0;
   always @(posedge clock_i) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];
   int            lat_q[$];
   logic [31:0]   last_addr = '0;
   logic [31:0]   last_data = '0;
   int            n_writes = 0;
   logic [31:0]   wbuf[MAXI];

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [EW-1:0] ev(logic [1:0] k, logic [31:0] a, logic [31:0] d);
      return {k, a, d};
   endfunction

   // Little-endian assembly: first byte received is the least significant.
   function automatic logic [31:0] assemble(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
      return (32'(b3) << 24) + (32'(b2) << 16) + (32'(b1) << 8) + 32'(b0);
   endfunction

   // scoreboard: every write/done/err pulse must match the next expected event
   always @(negedge clock_i) begin
      logic [EW-1:0] e;
      logic [1:0]    act_kind;
      if (!reset_i) begin
         check("reset_ctrl", {60'd0, en_write_o, done_o, err_o, busy_o}, 64'd0);
         check("reset_addr", 64'(address_o), 64'd0);
         check("reset_inst", 64'(inst_load_o), 64'd0);
         check("reset_ninst", 64'(n_inst_o), 64'd0);
      end else if (en_write_o || done_o || err_o) begin
         check("pulse_exclusive", 64'(int'(en_write_o) + int'(done_o) + int'(err_o)), 64'd1);
         act_kind = en_write_o ? K_WRITE : (done_o ? K_DONE : K_ERR);
         if (exp_q.size() == 0) begin
            check("unexpected_event", 64'(act_kind), 64'd3);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(act_kind), 64'(e[65:64]));
            if (en_write_o) begin
               check("write_addr", 64'(address_o), 64'(e[63:32]));
               check("write_data", 64'(inst_load_o), 64'(e[31:0]));
               if (lat_q.size() != 0) check("write_latency", 64'(cyc), 64'(lat_q.pop_front() + 1));
               else                   check("write_latency_missing", 64'd1, 64'd0);
               last_addr = address_o;
               last_data = inst_load_o;
               n_writes++;
            end
         end
      end
   end

   // driver tasks
   task automatic tick(int n);
      repeat (n) begin
         @(posedge clock_i);
         #1;
      end
   endtask

   task automatic send_byte(logic [7:0] b, bit last);
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      if (last) lat_q.push_back(cyc);
      tick(1);
      rx_valid_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick(1);
      start_i = 1'b0;
   endtask

   task automatic run_load(logic [7:0] count, int max_gap, bit noise);
      pulse_start();
      tick($urandom_range(0, max_gap));
      send_byte(count, 1'b0);
      if (count == 0 || int'(count) > MAXI) begin
         exp_q.push_back(ev(K_ERR, 32'd0, 32'd0));
      end else begin
         for (int i = 0; i < int'(count); i++) begin
            exp_q.push_back(ev(K_WRITE, 32'(4 * i), wbuf[i]));
            for (int k = 0; k < 4; k++) begin
               if (max_gap > 0) begin
                  if (noise && $urandom_range(0, 3) == 0) pulse_start();
                  tick($urandom_range(0, max_gap));
               end
               send_byte(wbuf[i][8*k +: 8], k == 3);
            end
         end
         exp_q.push_back(ev(K_DONE, 32'd0, 32'd0));
      end
      tick(3);
      if (noise) begin
         send_byte(8'($urandom_range(0, 255)), 1'b0);
         tick(1);
      end
   endtask

   task automatic fill_words(int n);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom();
   endtask

   initial begin
      int prev_writes;
      logic [7:0] cnt;

      reset_i = 1'b0;
      tick(3);
      reset_i = 1'b1;
      tick(2);

      // model pins
      check("model_pin_w0", 64'(assemble(8'h78, 8'h56, 8'h34, 8'h12)), 64'h12345678);
      check("model_pin_w1", 64'(assemble(8'hEF, 8'hBE, 8'hAD, 8'hDE)), 64'hDEADBEEF);

      // two-word reference load
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      run_load(8'h02, 0, 1'b0);
      tick(4);
      check("s1_last_data", 64'(last_data), 64'hDEADBEEF);
      check("s1_last_addr", 64'(last_addr), 64'h4);
      check("s1_addr_hold", 64'(address_o), 64'h4);
      check("s1_n_inst", 64'(n_inst_o), 64'h2);
      check("s1_idle", 64'(busy_o), 64'd0);

      // bad counts
      run_load(8'h00, 2, 1'b0);
      check("s2_zero_busy", 64'(busy_o), 64'd0);
      run_load(8'h41, 2, 1'b0);
      check("s2_over_busy", 64'(busy_o), 64'd0);
      check("s2_over_n_inst", 64'(n_inst_o), 64'h41);

      // noise in IDLE
      prev_writes = n_writes;
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h55, 1'b0);
         tick(1);
      end
      check("s3_idle_noise_busy", 64'(busy_o), 64'd0);
      check("s3_idle_noise_writes", 64'(n_writes), 64'(prev_writes));

      // reset after 2 of 4 bytes of word 1
      fill_words(2);
      pulse_start();
      send_byte(8'h02, 1'b0);
      exp_q.push_back(ev(K_WRITE, 32'h0, wbuf[0]));
      exp_q.push_back(ev(K_WRITE, 32'h4, wbuf[1]));
      exp_q.push_back(ev(K_DONE, 32'd0, 32'd0));
      for (int k = 0; k < 4; k++) send_byte(wbuf[0][8*k +: 8], k == 3);
      for (int k = 0; k < 2; k++) send_byte(wbuf[1][8*k +: 8], 1'b0);
      reset_i = 1'b0;
      #1;
      check("s4_async_busy", 64'(busy_o), 64'd0);
      check("s4_async_inst", 64'(inst_load_o), 64'd0);
      check("s4_async_addr", 64'(address_o), 64'd0);
      exp_q.delete();
      lat_q.delete();
      tick(2);
      reset_i = 1'b1;
      tick(3);
      check("s4_no_resume", 64'(busy_o), 64'd0);
      fill_words(1);
      run_load(8'h01, 1, 1'b0);
      check("s4_fresh_addr", 64'(last_addr), 64'h0);
      check("s4_fresh_data", 64'(last_data), 64'(wbuf[0]));

      // byte 0 of word 1 in the WRITE cycle of word 0
      fill_words(2);
      run_load(8'h02, 0, 1'b0);
      check("s5_wcycle_addr", 64'(last_addr), 64'h4);
      check("s5_wcycle_data", 64'(last_data), 64'(wbuf[1]));

      // maximum count
      fill_words(MAXI);
      run_load(8'(MAXI), 0, 1'b0);
      check("s6_max_addr", 64'(last_addr), 64'(4 * (MAXI - 1)));
      check("s6_max_data", 64'(last_data), 64'(wbuf[MAXI-1]));

      // randomized loads with start/rx noise
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            cnt = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXI + 1, 255));
         end else begin
            cnt = 8'($urandom_range(1, 4));
         end
         fill_words(4);
         run_load(cnt, 3, 1'b1);
      end

      // stall mid-word
      fill_words(1);
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(wbuf[0][7:0], 1'b0);
      send_byte(wbuf[0][15:8], 1'b0);
`ifdef LOADER_TIMEOUT_EN
      exp_q.push_back(ev(K_ERR, 32'd0, 32'd0));
      tick(TO + 20);
      check("s7_timeout_busy", 64'(busy_o), 64'd0);
`else
      tick(1000);
      check("s7_no_timeout_busy", 64'(busy_o), 64'd1);
      reset_i = 1'b0;
      tick(2);
      reset_i = 1'b1;
      tick(2);
`endif

      tick(5);
      check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter NB_DATA, default 32, sets the instruction word and address width.
REQ-002 Parameter N_BITS_DATA, default 8, sets the UART byte width.
REQ-003 Parameter N_BYTES, default 4, sets the number of bytes per instruction.
REQ-004 Parameter MAX_INST, default 64, sets the largest accepted instruction count.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000000, sets the inter-byte timeout in clocks; it is used only under LOADER_TIMEOUT_EN.
REQ-006 Port clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port start_i, input, 1 bit: one-cycle pulse from the debug FSM that arms a program load.
REQ-009 Port rx_data_i, input, N_BITS_DATA bits: byte received by the UART.
REQ-010 Port rx_valid_i, input, 1 bit: one-cycle strobe; rx_data_i is valid in that cycle.
REQ-011 Port en_write_o, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-012 Port address_o, output, NB_DATA bits: byte address of the word being written.
REQ-013 Port inst_load_o, output, NB_DATA bits: the assembled instruction word.
REQ-014 Port n_inst_o, output, N_BITS_DATA bits: the instruction count received.
REQ-015 Port busy_o, output, 1 bit: high in every state except IDLE.
REQ-016 Port done_o, output, 1 bit: one-cycle pulse when the load completes successfully.
REQ-017 Port err_o, output, 1 bit: one-cycle pulse when a load is aborted.

Function
REQ-018 The FSM has five states: IDLE, WAIT_COUNT, RECV, WRITE and DONE.
REQ-019 IDLE -> WAIT_COUNT on start_i; rx_valid_i is ignored in IDLE.
REQ-020 start_i is ignored in every state other than IDLE.
REQ-021 In WAIT_COUNT, an accepted byte is latched into n_inst_o.
REQ-022 A count byte of 0 or greater than MAX_INST pulses err_o and returns the FSM to IDLE.
REQ-023 A valid count byte (1 to MAX_INST) moves the FSM to RECV with byte counter = 0 and word counter = 0.
REQ-024 Bytes arrive least-significant first: byte k is written to inst_load_o[8k+7:8k].
REQ-025 The byte counter increments on each accepted byte in RECV.
REQ-026 When the byte at counter N_BYTES-1 is accepted, the FSM enters WRITE on the next edge.
REQ-027 WRITE lasts exactly one cycle, with en_write_o = 1 and address_o = 4 × word counter.
REQ-028 Write latency is 1 clock from acceptance of the last byte to the en_write_o cycle.
REQ-029 address_o and inst_load_o are stable for the entire en_write_o cycle.
REQ-030 An rx_valid_i arriving in the WRITE cycle is captured as byte 0 of the next word, and the byte counter becomes 1.
REQ-031 On leaving WRITE, the word counter increments.
REQ-032 If the incremented word counter equals n_inst_o, the FSM goes to DONE; otherwise it goes to RECV.
REQ-033 DONE pulses done_o for one cycle, then the FSM returns to IDLE.
REQ-034 After DONE, address_o holds the last written address until the next load begins.
REQ-035 Counters do not wrap: the word counter never exceeds MAX_INST, and address_o never exceeds 4 × (MAX_INST-1).
REQ-036 done_o, err_o and en_write_o are mutually exclusive in any cycle.

Reset
REQ-037 While reset_i = 0, the FSM is forced to IDLE asynchronously, regardless of the current state, including mid-load.
REQ-038 While reset_i = 0, every output and internal counter reads 0, and en_write_o never asserts.
REQ-039 Release of reset_i takes effect on the next rising edge of clock_i.
REQ-040 A load interrupted by reset does not resume; a new start_i is required.

Configuration
REQ-041 The macro LOADER_TIMEOUT_EN, when defined, adds an inter-byte watchdog counter that is active only in WAIT_COUNT and RECV.
REQ-042 The watchdog counter clears on every accepted byte.
REQ-043 When the watchdog reaches TIMEOUT_CYCLES, the block pulses err_o and returns to IDLE; no write is issued for the partial word.
REQ-044 Without LOADER_TIMEOUT_EN, no watchdog logic exists, and the FSM waits indefinitely for bytes.

Verification
REQ-045 Scenario: start_i, count 0x02, bytes 78 56 34 12 EF BE AD DE -> en_write_o twice: (addr 0x0, data 0x12345678), then (addr 0x4, data 0xDEADBEEF); then done_o for one cycle.
REQ-046 Scenario: start_i, count 0x00 -> err_o for one cycle, busy_o falls, no en_write_o; same with count 0x41 when MAX_INST = 64.
REQ-047 Scenario: rx_valid_i pulses in IDLE and start_i pulses in RECV -> no state change and no write.
REQ-048 Scenario: reset_i driven low after 2 of 4 bytes of word 1 -> all outputs 0 immediately; a fresh load of 1 word then writes addr 0x0 correctly.
REQ-049 Scenario: byte 0 of word 1 strobed in the WRITE cycle of word 0 -> word 1 is assembled correctly and written at addr 0x4.
REQ-050 Scenario (LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 100): stall 100 cycles after byte 2 -> err_o pulses, no write; without the macro, the bench sees busy_o still high after 1000 cycles.
